// File: rtl/render_page_controller.sv
// Paged render sequencer: debounced next/prev keys step a page start address and each page is
// rendered through a start/done handshake. Optional periodic re-render: RENDER_AUTO_REFRESH_EN.
module render_page_controller #(
    parameter int unsigned ADDR_W       = 20,
    parameter int unsigned PAGE_BYTES   = 928,
    parameter int unsigned NUM_PAGES    = 16,
    parameter int unsigned WRAP         = 1,
    parameter int unsigned DEBOUNCE_CYC = 250000,
    parameter int unsigned TIMEOUT_CYC  = 4000000,
    parameter int unsigned CLK_HZ       = 50000000,
    parameter int unsigned REFRESH_HZ   = 1,
    localparam int unsigned IDX_W       = (NUM_PAGES > 1) ? $clog2(NUM_PAGES) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key_next_n,
    input  logic              key_prev_n,
    input  logic              render_done,
    output logic              render_start,
    output logic              render_rst_n,
    output logic [ADDR_W-1:0] page_addr,
    output logic [IDX_W-1:0]  page_idx,
    output logic              render_err,
    output logic [7:0]        state
);

    localparam int unsigned DB_W = $clog2(DEBOUNCE_CYC + 1);
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);

    localparam logic [ADDR_W-1:0] STEP      = ADDR_W'(PAGE_BYTES);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'((NUM_PAGES - 1) * PAGE_BYTES);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_PAGES - 1);

    typedef enum logic [7:0] {
        ST_START        = 8'h00,
        ST_START_RENDER = 8'h07,
        ST_WAIT_RENDER  = 8'h08,
        ST_RENDER_DONE  = 8'h09,
        ST_WAIT_INPUT   = 8'h0A,
        ST_NEXT         = 8'h0B,
        ST_PREV         = 8'h0C,
        ST_WAIT_NEXT    = 8'h0D,
        ST_WAIT_PREV    = 8'h0E,
        ST_ERR          = 8'hFF
    } state_t;

    // Elaboration-time parameter sanity check
    if (NUM_PAGES < 1 || REFRESH_HZ < 1 || CLK_HZ < REFRESH_HZ ||
        DEBOUNCE_CYC < 1 || TIMEOUT_CYC < 1) begin : g_bad_cfg
        $error("render_page_controller: invalid parameter set");
    end

    state_t state_q;
    state_t state_d;

    logic [1:0]      key_raw;
    logic [1:0]      key_meta;
    logic [1:0]      key_sync;
    logic [1:0]      key_db;
    logic [DB_W-1:0] db_cnt [2];
    logic            next_held;
    logic            prev_held;

    logic [TO_W-1:0] to_cnt;
    logic            timeout;
    logic            err_set;
    logic            refresh_due;

    assign key_raw   = {key_prev_n, key_next_n};
    assign next_held = ~key_db[0];
    assign prev_held = ~key_db[1];

    // 2-FF synchroniser and per-key stability counter; released (1) out of reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_meta <= 2'b11;
            key_sync <= 2'b11;
            key_db   <= 2'b11;
            for (int k = 0; k < 2; k++) begin
                db_cnt[k] <= '0;
            end
        end else begin
            key_meta <= key_raw;
            key_sync <= key_meta;
            for (int k = 0; k < 2; k++) begin
                if (key_sync[k] == key_db[k]) begin
                    db_cnt[k] <= '0;
                end else if (db_cnt[k] == DB_W'(DEBOUNCE_CYC - 1)) begin
                    db_cnt[k] <= '0;
                    key_db[k] <= key_sync[k];
                end else begin
                    db_cnt[k] <= db_cnt[k] + DB_W'(1);
                end
            end
        end
    end

    // Render timeout: counts cycles spent in WAIT_RENDER
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            to_cnt <= '0;
        end else if (state_q == ST_WAIT_RENDER) begin
            to_cnt <= to_cnt + TO_W'(1);
        end else begin
            to_cnt <= '0;
        end
    end

    assign timeout = (state_q == ST_WAIT_RENDER) && (to_cnt == TO_W'(TIMEOUT_CYC - 1));

`ifdef RENDER_AUTO_REFRESH_EN
    localparam int unsigned REFRESH_DIV = CLK_HZ / REFRESH_HZ;
    localparam int unsigned REF_W       = $clog2(REFRESH_DIV + 1);

    logic [REF_W-1:0] ref_cnt;

    // Idle refresh counter, restarts on every entry into WAIT_INPUT
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ref_cnt <= '0;
        end else if (state_q == ST_WAIT_INPUT) begin
            ref_cnt <= ref_cnt + REF_W'(1);
        end else begin
            ref_cnt <= '0;
        end
    end

    assign refresh_due = (state_q == ST_WAIT_INPUT) && (ref_cnt == REF_W'(REFRESH_DIV - 1));
`else
    assign refresh_due = 1'b0;
`endif

    // Next-state logic
    always_comb begin
        state_d = state_q;
        err_set = 1'b0;
        case (state_q)
            ST_START:        state_d = ST_START_RENDER;
            ST_START_RENDER: state_d = ST_WAIT_RENDER;
            ST_WAIT_RENDER: begin
                if (render_done) begin
                    state_d = ST_RENDER_DONE;
                end else if (timeout) begin
                    state_d = ST_RENDER_DONE;
                    err_set = 1'b1;
                end
            end
            ST_RENDER_DONE:  state_d = ST_WAIT_INPUT;
            ST_WAIT_INPUT: begin
                if (next_held) begin
                    state_d = ST_NEXT;
                end else if (prev_held) begin
                    state_d = ST_PREV;
                end else if (refresh_due) begin
                    state_d = ST_START_RENDER;
                end
            end
            ST_NEXT:         state_d = ST_WAIT_NEXT;
            ST_PREV:         state_d = ST_WAIT_PREV;
            ST_WAIT_NEXT: begin
                if (!next_held) begin
                    state_d = ST_START_RENDER;
                end
            end
            ST_WAIT_PREV: begin
                if (!prev_held) begin
                    state_d = ST_START_RENDER;
                end
            end
            ST_ERR:          state_d = ST_ERR;
            default:         state_d = ST_ERR;
        endcase
    end

    // State register; handshake outputs registered alongside the state they belong to
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_START;
            render_start <= 1'b0;
            render_rst_n <= 1'b1;
        end else begin
            state_q      <= state_d;
            render_start <= (state_d == ST_START_RENDER);
            render_rst_n <= (state_d != ST_RENDER_DONE);
        end
    end

    assign state = state_q;

    // Page index and address step together; address is tracked incrementally
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            page_idx  <= '0;
            page_addr <= '0;
        end else if (state_q == ST_NEXT) begin
            if (page_idx != LAST_IDX) begin
                page_idx  <= page_idx + IDX_W'(1);
                page_addr <= page_addr + STEP;
            end else if (WRAP != 0) begin
                page_idx  <= '0;
                page_addr <= '0;
            end
        end else if (state_q == ST_PREV) begin
            if (page_idx != '0) begin
                page_idx  <= page_idx - IDX_W'(1);
                page_addr <= page_addr - STEP;
            end else if (WRAP != 0) begin
                page_idx  <= LAST_IDX;
                page_addr <= LAST_ADDR;
            end
        end
    end

    // Sticky render timeout flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            render_err <= 1'b0;
        end else if (err_set) begin
            render_err <= 1'b1;
        end
    end

endmodule
